spi_flash_burst_reader: RTL

- Parameterised successor to the single-word SPI flash fetch block.
- Issues a READ command at a programmable 24-bit flash address and streams a programmable number of words over a valid/ready interface.
- SCLK rate, word width and CS inter-burst gap are parameters. Backpressure is handled by pausing SCLK.
- Sits between the flash pins (SCLK routed through the STARTUPE2 user CCLK input) and the consumer, e.g. a ROM preloader for the C64 core memories.

---
 rtl/spi_flash_pkg.sv | 18 +
 rtl/spi_flash_burst_reader_sclk_gen.sv | 36 +++
 rtl/spi_flash_burst_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared opcodes, frame sizes and FSM state encoding for the SPI flash burst reader.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam int         ADDR_BITS    = 24;
    localparam int         DUMMY_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_flash_burst_reader_sclk_gen.sv
// spi_sclk_gen: divides clk into SPI mode-0 SCLK, emitting rise/fall strobes in the cycle that drives each edge.
module spi_sclk_gen
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pause,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = !clear && !pause && cnt == CW'(CLK_DIV - 1);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Count out each half-period and toggle sclk at its end; pause freezes, clear parks low
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!pause) begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            sclk <= sclk ^ tick;
        end
    end

endmodule

// File: rtl/spi_flash_burst_reader.sv
// spi_flash_burst_reader: SPI flash READ burst engine streaming words over valid/ready.
// Build option: define SPI_FAST_READ_EN for opcode 0x0B plus 8 dummy clocks after the address.
module spi_flash_burst_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int WORD_BYTES  = 4,
    parameter int LEN_W       = 16,
    parameter int CS_HIGH_CYC = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [23:0]             start_addr,
    input  logic [LEN_W-1:0]        length,
    output logic                    busy,
    output logic                    done,
    output logic [8*WORD_BYTES-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    spi_cs_n,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam int W   = 8 * WORD_BYTES;
    localparam int WBW = $clog2(W);
    localparam int CSW = $clog2(CS_HIGH_CYC + 2);
    localparam int GW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE = OP_FAST_READ;
    localparam state_t     AFTER_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] OPCODE = OP_READ;
    localparam state_t     AFTER_ADDR = ST_DATA;
`endif

    state_t           state;
    logic [31:0]      tx;
    logic [4:0]       hcnt;
    logic [WBW-1:0]   wbit;
    logic [W-1:0]     rx;
    logic [LEN_W-1:0] words_left;
    logic [CSW-1:0]   cs_hi;
    logic [GW-1:0]    tail;
    logic             rise;
    logic             fall;
    logic             pause;
    logic             clear;
    logic             last_bit;

    // Header bits leave MSB first; once shifted out the register holds zeros, so MOSI idles low
    assign spi_mosi = tx[31];
    assign clear    = state == ST_IDLE || state == ST_GAP;
    assign last_bit = wbit == WBW'(W - 1);
    // Withhold the rising edge of a word's last bit while the previous word is still unaccepted
    assign pause    = state == ST_DATA && last_bit && !spi_sclk && m_valid && !m_ready;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .pause (pause),
        .sclk  (spi_sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // Burst sequencer: command/address shift-out, data capture, output handshake and CS spacing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tx         <= '0;
            hcnt       <= '0;
            wbit       <= '0;
            rx         <= '0;
            words_left <= '0;
            cs_hi      <= CSW'(CS_HIGH_CYC);
            tail       <= '0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            done  <= 1'b0;
            cs_hi <= (spi_cs_n && cs_hi != CSW'(CS_HIGH_CYC)) ? cs_hi + 1'b1 : cs_hi;
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (fall)
                tx <= {tx[30:0], 1'b0};
            case (state)
                ST_IDLE: begin
                    if (start && length == '0) begin
                        done <= 1'b1;
                    end else if (start) begin
                        state      <= ST_CMD;
                        busy       <= 1'b1;
                        spi_cs_n   <= 1'b0;
                        cs_hi      <= '0;
                        tx         <= {OPCODE, start_addr};
                        words_left <= length;
                        hcnt       <= '0;
                        wbit       <= '0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        hcnt  <= (hcnt == 5'd7) ? '0 : hcnt + 5'd1;
                        state <= (hcnt == 5'd7) ? ST_ADDR : ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        hcnt  <= (hcnt == 5'(ADDR_BITS - 1)) ? '0 : hcnt + 5'd1;
                        state <= (hcnt == 5'(ADDR_BITS - 1)) ? AFTER_ADDR : ST_ADDR;
                    end
                end
`ifdef SPI_FAST_READ_EN
                ST_DUMMY: begin
                    if (rise) begin
                        hcnt  <= (hcnt == 5'(DUMMY_BITS - 1)) ? '0 : hcnt + 5'd1;
                        state <= (hcnt == 5'(DUMMY_BITS - 1)) ? ST_DATA : ST_DUMMY;
                    end
                end
`endif
                ST_DATA: begin
                    if (rise) begin
                        rx   <= {rx[W-2:0], spi_miso};
                        wbit <= last_bit ? '0 : wbit + 1'b1;
                        if (last_bit) begin
                            m_data     <= {rx[W-2:0], spi_miso};
                            m_valid    <= 1'b1;
                            words_left <= words_left - 1'b1;
                        end
                    end
                    // The fall after the final sampled bit ends the transfer; CS follows a half-period later
                    if (fall && words_left == '0) begin
                        state <= ST_GAP;
                        tail  <= '0;
                    end
                end
                ST_GAP: begin
                    if (!spi_cs_n) begin
                        tail <= tail + 1'b1;
                        if (tail == GW'(CLK_DIV - 1))
                            spi_cs_n <= 1'b1;
                    end else if (cs_hi == CSW'(CS_HIGH_CYC) && !m_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
